// File: rtl/sensor_slot_scheduler.sv
// Slot-multiplexed sensor round scheduler: broadcasts sample_en, then decodes 4096 RUN slots.
// Optional automatic round restart is enabled by defining SENSOR_AUTO_RESTART_EN.
module sensor_slot_scheduler #(
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk_division,
  input  logic        rst_n,
  input  logic        start,
  input  logic        slot_bus,
  output logic        sample_en,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  result_addr,
  output logic [7:0]  result_data,
  output logic        done,
  output logic [15:0] missing_mask,
  output logic        dup_err
);

  typedef enum logic [2:0] {BLANK, IDLE, ARM, RUN, DONE} state_t;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 4096) begin : g_bad_gap
    $error("GAP_CYCLES must be within 1..4096");
  end

  state_t      state_q, state_d;
  // One counter serves BLANK timing, the RUN {data_cnt, slot_cnt} pair and the idle gap.
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] seen_q, seen_d;
  logic        sample_en_q, sample_en_d;
  logic        busy_q, busy_d;
  logic        result_valid_q, result_valid_d;
  logic [3:0]  result_addr_q, result_addr_d;
  logic [7:0]  result_data_q, result_data_d;
  logic        done_q, done_d;
  logic [15:0] missing_mask_q, missing_mask_d;
  logic        dup_err_q, dup_err_d;
  logic        go_arm;
  logic [3:0]  slot_cnt;
  logic [7:0]  data_cnt;

  assign slot_cnt = cnt_q[3:0];
  assign data_cnt = cnt_q[11:4];

`ifdef SENSOR_AUTO_RESTART_EN
  localparam logic [11:0] GAP_LAST = 12'(GAP_CYCLES - 1);
  logic auto_q, auto_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    seen_d         = seen_q;
    sample_en_d    = 1'b0;
    result_valid_d = 1'b0;
    result_addr_d  = result_addr_q;
    result_data_d  = result_data_q;
    done_d         = 1'b0;
    missing_mask_d = missing_mask_q;
    dup_err_d      = dup_err_q;
    go_arm         = 1'b0;
`ifdef SENSOR_AUTO_RESTART_EN
    auto_d         = auto_q;
`endif
    case (state_q)
      BLANK: begin
        cnt_d = cnt_q + 12'd1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (start) begin
          go_arm = 1'b1;
`ifdef SENSOR_AUTO_RESTART_EN
        end else if (auto_q) begin
          if (cnt_q == GAP_LAST) go_arm = 1'b1;
          else cnt_d = cnt_q + 12'd1;
`endif
        end
        if (go_arm) begin
          state_d     = ARM;
          sample_en_d = 1'b1;
          seen_d      = '0;
          dup_err_d   = 1'b0;
          cnt_d       = '0;
`ifdef SENSOR_AUTO_RESTART_EN
          auto_d      = 1'b0;
`endif
        end
      end
      ARM: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + 12'd1;
        if (slot_bus) begin
          if (!seen_q[slot_cnt]) begin
            seen_d[slot_cnt] = 1'b1;
            result_valid_d   = 1'b1;
            result_addr_d    = slot_cnt;
            result_data_d    = data_cnt;
          end else begin
            dup_err_d = 1'b1;
          end
        end
        // Mask uses seen_d so a pulse in the final slot still counts as present.
        if (&cnt_q) begin
          state_d        = DONE;
          done_d         = 1'b1;
          missing_mask_d = ~seen_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
`ifdef SENSOR_AUTO_RESTART_EN
        auto_d  = 1'b1;
`endif
      end
      default: state_d = BLANK;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_division or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BLANK;
      cnt_q          <= '0;
      seen_q         <= '0;
      sample_en_q    <= 1'b0;
      busy_q         <= 1'b1;
      result_valid_q <= 1'b0;
      result_addr_q  <= '0;
      result_data_q  <= '0;
      done_q         <= 1'b0;
      missing_mask_q <= '0;
      dup_err_q      <= 1'b0;
`ifdef SENSOR_AUTO_RESTART_EN
      auto_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      sample_en_q    <= sample_en_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_addr_q  <= result_addr_d;
      result_data_q  <= result_data_d;
      done_q         <= done_d;
      missing_mask_q <= missing_mask_d;
      dup_err_q      <= dup_err_d;
`ifdef SENSOR_AUTO_RESTART_EN
      auto_q         <= auto_d;
`endif
    end
  end

  assign sample_en    = sample_en_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_addr  = result_addr_q;
  assign result_data  = result_data_q;
  assign done         = done_q;
  assign missing_mask = missing_mask_q;
  assign dup_err      = dup_err_q;

endmodule

// File: tb/tb_sensor_slot_scheduler.sv
// Directed testbench for sensor_slot_scheduler: reset blanking, decode rounds, duplicates, abort.
module tb_sensor_slot_scheduler;

  logic        clk_division = 1'b0;
  logic        rst_n;
  logic        start;
  logic        slot_bus;
  logic        sample_en;
  logic        busy;
  logic        result_valid;
  logic [3:0]  result_addr;
  logic [7:0]  result_data;
  logic        done;
  logic [15:0] missing_mask;
  logic        dup_err;

  always #5 clk_division = ~clk_division;

  sensor_slot_scheduler #(.GAP_CYCLES(16)) dut (
    .clk_division (clk_division),
    .rst_n        (rst_n),
    .start        (start),
    .slot_bus     (slot_bus),
    .sample_en    (sample_en),
    .busy         (busy),
    .result_valid (result_valid),
    .result_addr  (result_addr),
    .result_data  (result_data),
    .done         (done),
    .missing_mask (missing_mask),
    .dup_err      (dup_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Sensor stimulus table: sensor pa[k] answers with value pv[k] in slot (pv*16 + pa).
  int          pa [4];
  int          pv [4];
  int          np;
  logic [3:0]  got_addr [8];
  logic [7:0]  got_data [8];
  int          got_idx  [8];
  int          nres;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_division);
    #1;
  endtask

  task automatic record(input int idx);
    if (nres < 8) begin
      got_addr[nres] = result_addr;
      got_data[nres] = result_data;
      got_idx[nres]  = idx;
    end
    nres++;
  endtask

  // Runs one complete round; returns in the first IDLE cycle after DONE.
  task automatic run_round(input string tag, input int start_at);
    int   se_cnt;
    int   dn_cnt;
    logic sb;
    se_cnt = 0;
    dn_cnt = 0;
    nres   = 0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check_eq({tag, "_arm_sample_en"}, sample_en, 1);
    check_eq({tag, "_arm_busy"}, busy, 1);
    tick();
    check_eq({tag, "_run0_dup_err"}, dup_err, 0);
    for (int j = 0; j < 4096; j++) begin
      sb = 1'b0;
      for (int k = 0; k < np; k++) if (pv[k] * 16 + pa[k] == j) sb = 1'b1;
      slot_bus = sb;
      start    = (j == start_at);
      if (result_valid) record(j);
      if (sample_en) se_cnt++;
      if (done) dn_cnt++;
      tick();
    end
    slot_bus = 1'b0;
    start    = 1'b0;
    if (result_valid) record(4096);
    check_eq({tag, "_done_pulse"}, done, 1);
    check_eq({tag, "_done_busy"}, busy, 1);
    check_eq({tag, "_run_sample_en_cnt"}, se_cnt, 0);
    check_eq({tag, "_run_done_cnt"}, dn_cnt, 0);
    tick();
    check_eq({tag, "_post_done"}, done, 0);
    check_eq({tag, "_post_busy"}, busy, 0);
  endtask

  // Holds BLANK for its full length while slot_bus chatters; start at cycle 10 must be ignored.
  task automatic blank_phase(input string tag);
    int bcnt, scnt, rcnt, dcnt;
    bcnt = 0; scnt = 0; rcnt = 0; dcnt = 0;
    for (int i = 0; i < 4096; i++) begin
      start    = (i == 10);
      slot_bus = i[0];
      if (busy) bcnt++;
      if (sample_en) scnt++;
      if (result_valid) rcnt++;
      if (done) dcnt++;
      tick();
    end
    start    = 1'b0;
    slot_bus = 1'b0;
    check_eq({tag, "_busy_cycles"}, bcnt, 4096);
    check_eq({tag, "_sample_en_cnt"}, scnt, 0);
    check_eq({tag, "_result_cnt"}, rcnt, 0);
    check_eq({tag, "_done_cnt"}, dcnt, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    slot_bus = 1'b0;
    np       = 0;
    tick();
    tick();
    check_eq("rst_busy", busy, 1);
    check_eq("rst_sample_en", sample_en, 0);
    check_eq("rst_result_valid", result_valid, 0);
    check_eq("rst_result_addr", result_addr, 0);
    check_eq("rst_result_data", result_data, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_missing_mask", missing_mask, 0);
    check_eq("rst_dup_err", dup_err, 0);
    rst_n = 1'b1;
    blank_phase("blank0");

    pa[0] = 3; pv[0] = 8'h5A; np = 1;
    run_round("r1", -1);
    check_eq("r1_nres", nres, 1);
    check_eq("r1_addr", got_addr[0], 3);
    check_eq("r1_data", got_data[0], 8'h5A);
    check_eq("r1_idx", got_idx[0], 1444);
    check_eq("r1_mask", missing_mask, 16'hFFF7);
    check_eq("r1_dup", dup_err, 0);

    pa[0] = 0; pv[0] = 8'h00; pa[1] = 15; pv[1] = 8'hFF; np = 2;
    run_round("r2", -1);
    check_eq("r2_nres", nres, 2);
    check_eq("r2_addr0", got_addr[0], 0);
    check_eq("r2_data0", got_data[0], 8'h00);
    check_eq("r2_idx0", got_idx[0], 1);
    check_eq("r2_addr1", got_addr[1], 15);
    check_eq("r2_data1", got_data[1], 8'hFF);
    check_eq("r2_idx1_in_done", got_idx[1], 4096);
    check_eq("r2_mask", missing_mask, 16'h7FFE);

    pa[0] = 3; pv[0] = 8'h5A; pa[1] = 3; pv[1] = 8'h80; np = 2;
    run_round("r3", -1);
    check_eq("r3_nres", nres, 1);
    check_eq("r3_addr", got_addr[0], 3);
    check_eq("r3_data", got_data[0], 8'h5A);
    check_eq("r3_dup", dup_err, 1);
    check_eq("r3_mask", missing_mask, 16'hFFF7);

    pa[0] = 7; pv[0] = 8'h12; pa[1] = 9; pv[1] = 8'h12; pa[2] = 1; pv[2] = 8'hC3; np = 3;
    run_round("r4", 100);
    check_eq("r4_nres", nres, 3);
    check_eq("r4_addr0", got_addr[0], 7);
    check_eq("r4_idx0", got_idx[0], 296);
    check_eq("r4_addr1", got_addr[1], 9);
    check_eq("r4_data1", got_data[1], 8'h12);
    check_eq("r4_addr2", got_addr[2], 1);
    check_eq("r4_data2", got_data[2], 8'hC3);
    check_eq("r4_idx2", got_idx[2], 3122);
    check_eq("r4_mask", missing_mask, 16'hFD7D);
    check_eq("r4_dup", dup_err, 0);
`ifndef SENSOR_AUTO_RESTART_EN
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (sample_en || busy) cnt++;
      tick();
    end
    check_eq("r4_no_auto_restart", cnt, 0);
    check_eq("r4_mask_hold", missing_mask, 16'hFD7D);
`endif

    // Abort a round with reset at RUN cycle 2000; a start pulse mid-RUN must not queue.
    pa[0] = 5; pv[0] = 8'h10; np = 1;
    cnt   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int j = 0; j < 2000; j++) begin
      slot_bus = (j == 261);
      start    = (j == 50);
      if (done || sample_en) cnt++;
      tick();
    end
    slot_bus = 1'b0;
    start    = 1'b0;
    check_eq("abort_pre_cnt", cnt, 0);
    check_eq("abort_pre_addr", result_addr, 5);
    check_eq("abort_pre_data", result_data, 8'h10);
    rst_n = 1'b0;
    #1;
    check_eq("abort_rst_busy", busy, 1);
    check_eq("abort_rst_done", done, 0);
    check_eq("abort_rst_addr", result_addr, 0);
    check_eq("abort_rst_data", result_data, 0);
    check_eq("abort_rst_mask", missing_mask, 0);
    tick();
    tick();
    rst_n = 1'b1;
    blank_phase("blank1");
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (sample_en || busy || done) cnt++;
      tick();
    end
    check_eq("abort_no_second_round", cnt, 0);

`ifdef SENSOR_AUTO_RESTART_EN
    np = 0;
    run_round("auto", -1);
    cnt = 1;
    while (!sample_en && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("auto_gap", cnt, 17);
    cnt = 0;
    while (!done && cnt < 4200) begin
      tick();
      cnt++;
    end
    check_eq("auto_repeat_done", cnt, 4097);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_slot_scheduler.md
SENSOR_SLOT_SCHEDULER -- requirements
Module: sensor_slot_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, idle cycles between automatic rounds (used only with SENSOR_AUTO_RESTART_EN).
REQ-002 SHALL have port clk_division  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request one sampling round; sampled on rising edge.
REQ-005 SHALL have port slot_bus  input  1  wired-OR of the slot outputs of up to 16 sensor interfaces.
REQ-006 SHALL have port sample_en  output  1  one-cycle pulse broadcast to all sensor interfaces.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port result_valid  output  1  one-cycle strobe per decoded sensor value.
REQ-009 SHALL have port result_addr  output  4  sensor address of the current result.
REQ-010 SHALL have port result_data  output  8  decoded sensor value of the current result.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of round.
REQ-012 SHALL have port missing_mask  output  16  bit a set = no pulse from address a in the last round.
REQ-013 SHALL have port dup_err  output  1  sticky: a second pulse arrived for an already-decoded address.

Function
REQ-014 SHALL implement states BLANK, IDLE, ARM, RUN, DONE; all outputs registered.
REQ-015 IDLE -> ARM on start=1; start in any other state SHALL be ignored, not queued.
REQ-016 ARM SHALL last exactly one cycle with sample_en=1; sample_en SHALL be 0 in all other states.
REQ-017 ARM -> RUN; on entry, 4-bit slot_cnt and 8-bit data_cnt SHALL be 0.
REQ-018 In RUN, slot_cnt SHALL increment every cycle, wrapping 15->0; data_cnt SHALL increment when slot_cnt==15.
REQ-019 RUN SHALL last exactly 4096 cycles; RUN -> DONE in the cycle after slot_cnt==15 and data_cnt==255.
REQ-020 In RUN, slot_bus=1 in a cycle with counters (s,d) and seen[s]=0 SHALL set seen[s] and give result_valid=1, result_addr=s, result_data=d one cycle later.
REQ-021 slot_bus=1 with seen[s]=1 SHALL set dup_err and SHALL NOT strobe result_valid.
REQ-022 slot_bus SHALL be ignored outside RUN.
REQ-023 DONE SHALL last one cycle with done=1 and SHALL load missing_mask with ~seen.
REQ-024 DONE -> IDLE.
REQ-025 missing_mask SHALL hold until the next DONE.
REQ-026 On ARM, seen SHALL be cleared to 0 and dup_err SHALL be cleared.
REQ-027 A result strobe for a pulse in the last RUN cycle SHALL coincide with the DONE cycle; that address SHALL be cleared in missing_mask.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state BLANK and clear all counters and seen.
REQ-029 rst_n=0 SHALL clear outputs: sample_en=0, result_valid=0, result_addr=0, result_data=0, done=0, missing_mask=0, dup_err=0.
REQ-030 busy SHALL be 1 while in BLANK.
REQ-031 BLANK SHALL last 4096 cycles after rst_n deassertion, because sensor interfaces are not reset and may be mid-round; BLANK -> IDLE afterwards.
REQ-032 BLANK SHALL issue no sample_en and SHALL decode no slot_bus pulses.
REQ-033 Reset asserted during RUN SHALL abort the round without producing a done pulse.

Configuration
REQ-034 With SENSOR_AUTO_RESTART_EN defined: DONE -> IDLE -> ARM automatically after GAP_CYCLES idle cycles; start is still accepted in IDLE and SHALL restart the round immediately.
REQ-035 Without SENSOR_AUTO_RESTART_EN defined: a round begins only on start; the gap counter SHALL NOT be synthesized.

Verification
REQ-036 Reset release, then start at cycle 10 -> start ignored, busy=1 through 4096 BLANK cycles, no sample_en.
REQ-037 After BLANK, start with sensor addr 3 = 0x5A -> sample_en for one cycle, result_valid with addr=3, data=0x5A, done 4098 cycles after start.
REQ-038 Round with sensors 0 (0x00) and 15 (0xFF) only -> two results (0x00 first, 0xFF strobing in the DONE cycle), missing_mask=0x7FFE.
REQ-039 Inject a second slot_bus pulse for addr 3 later in the round -> dup_err=1, single result only; next start clears dup_err.
REQ-040 start pulsed during RUN, and rst_n pulled low at RUN cycle 2000 -> no second round, no done pulse; BLANK restarts.
REQ-041 SENSOR_AUTO_RESTART_EN with GAP_CYCLES=16 -> next sample_en 17 cycles after done, rounds repeat without start.
